// File: rtl/fp32_pkg.sv
// Shared constants and the S1->S2 stage record for the FP32 multiplier back end.
// All datapath widths in fp32_mul_round and fp_mant_round derive from these constants.
package fp32_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int PW      = 2 * (MAN_W + 1);
    // Internal exponent carries headroom for the normalise and round-carry bumps.
    localparam int EW      = EXP_W + 3;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic                 sign;
        logic signed [EW-1:0] e;
        logic [MAN_W-1:0]     man;
        logic                 g;
        logic                 st;
        logic                 zero;
        logic                 inf;
        logic                 nan;
    } s1_rec_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inexact;
    } fp_flags_t;

    function automatic logic [31:0] fp_pack(input logic             sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [MAN_W-1:0] man);
        return {sign, exp, man};
    endfunction

endpackage

// File: rtl/fp_mant_round.sv
// Mantissa rounder: applies the rounding increment to a normalised mantissa.
// FPMUL_RNE_EN defined selects round-to-nearest-even; undefined truncates.
module fp_mant_round
    import fp32_pkg::*;
(
    input  logic [MAN_W-1:0] man_i,
    input  logic             g_i,
    input  logic             st_i,
    output logic [MAN_W-1:0] man_rnd_o,
    output logic             carry_o
);

    logic rnd_inc;

`ifdef FPMUL_RNE_EN
    always_comb begin
        rnd_inc = g_i & (st_i | man_i[0]);
    end
`else
    logic unused_rnd;
    assign unused_rnd = ^{g_i, st_i};

    always_comb begin
        rnd_inc = 1'b0;
    end
`endif

    // An all-ones mantissa wraps to zero and signals the exponent bump through carry_o.
    assign {carry_o, man_rnd_o} = {1'b0, man_i} + {{MAN_W{1'b0}}, rnd_inc};

endmodule

// File: rtl/fp32_mul_round.sv
// FP32 multiplier back end: normalise (S1), round/range-check/pack (S2), valid/ready pipeline.
// Rounding mode is chosen by FPMUL_RNE_EN inside fp_mant_round (undefined: truncate).
module fp32_mul_round
    import fp32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W+1:0] in_exp,
    input  logic [PW-1:0]    in_prod,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inexact
);

    localparam logic signed [EW-1:0] E_MAX  = EW'(EXP_MAX);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    logic                 adv;
    logic signed [EW-1:0] e_in;
    s1_rec_t              s1_d, s1_q;
    logic                 s1_valid_q;
    logic                 out_valid_q;
    logic [31:0]          out_data_d, out_data_q;
    fp_flags_t            flags_d, flags_q;
    logic [MAN_W-1:0]     man_rnd;
    logic                 rnd_carry;
    logic signed [EW-1:0] e_rnd;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign e_in     = {{(EW-EXP_W-2){in_exp[EXP_W+1]}}, in_exp};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.zero = in_zero;
        s1_d.inf  = in_inf;
        s1_d.nan  = in_nan;
        if (in_prod[PW-1]) begin
            s1_d.man = in_prod[PW-2 -: MAN_W];
            s1_d.g   = in_prod[PW-MAN_W-2];
            s1_d.st  = |in_prod[PW-MAN_W-3:0];
            s1_d.e   = e_in + EW'(1);
        end else begin
            s1_d.man = in_prod[PW-3 -: MAN_W];
            s1_d.g   = in_prod[PW-MAN_W-3];
            s1_d.st  = |in_prod[PW-MAN_W-4:0];
            s1_d.e   = e_in;
        end
    end

    fp_mant_round u_round (
        .man_i     (s1_q.man),
        .g_i       (s1_q.g),
        .st_i      (s1_q.st),
        .man_rnd_o (man_rnd),
        .carry_o   (rnd_carry)
    );

    assign e_rnd = s1_q.e + {{(EW-1){1'b0}}, rnd_carry};

    // Specials take priority nan > inf > zero over the arithmetic result.
    always_comb begin
        out_data_d = '0;
        flags_d    = '0;
        if (s1_q.nan) begin
            out_data_d = QNAN;
        end else if (s1_q.inf) begin
            out_data_d = {s1_q.sign, POS_INF[30:0]};
        end else if (s1_q.zero) begin
            out_data_d = {s1_q.sign, 31'b0};
        end else if (e_rnd >= E_MAX) begin
            out_data_d = {s1_q.sign, POS_INF[30:0]};
            flags_d    = '{ovf: 1'b1, unf: 1'b0, inexact: 1'b1};
        end else if (e_rnd <= E_ZERO) begin
            out_data_d = {s1_q.sign, 31'b0};
            flags_d    = '{ovf: 1'b0, unf: 1'b1, inexact: 1'b1};
        end else begin
            out_data_d = fp_pack(s1_q.sign, e_rnd[EXP_W-1:0], man_rnd);
            flags_d    = '{ovf: 1'b0, unf: 1'b0, inexact: s1_q.g | s1_q.st};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                flags_q    <= flags_d;
            end
        end
    end

    // NOTE: the S1 payload is deliberately left unreset; s1_valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_q <= s1_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ovf     = flags_q.ovf;
    assign out_unf     = flags_q.unf;
    assign out_inexact = flags_q.inexact;

endmodule
